// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle control unit.
//   - state_t     : main controller state encoding
//   - ctrl_t      : bundle of all controller outputs
//   - select encodings for adr_src, result_src, alu_src_a, alu_src_b, alu_op
//   - the nine legal opcodes and the ALU control codes produced by alu_dec
package main_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal,
    StJalr,
    StLui,
    StAuipc,
    StTrap
  } state_t;

  // adr_src
  localparam logic       AdrPc        = 1'b0;
  localparam logic       AdrResult    = 1'b1;
  // result_src
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  // alu_src_a
  localparam logic [1:0] SrcAPc       = 2'b00;
  localparam logic [1:0] SrcAOldPc    = 2'b01;
  localparam logic [1:0] SrcARs1      = 2'b10;
  localparam logic [1:0] SrcAZero     = 2'b11;
  // alu_src_b
  localparam logic [1:0] SrcBRs2      = 2'b00;
  localparam logic [1:0] SrcBImm      = 2'b01;
  localparam logic [1:0] SrcBFour     = 2'b10;
  // alu_op
  localparam logic [1:0] AluOpAdd     = 2'b00;
  localparam logic [1:0] AluOpSub     = 2'b01;
  localparam logic [1:0] AluOpFunct   = 2'b10;

  // Legal opcodes
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBeq    = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // ALU control codes
  localparam logic [2:0] AluCtrlAdd = 3'b000;
  localparam logic [2:0] AluCtrlSub = 3'b001;
  localparam logic [2:0] AluCtrlAnd = 3'b010;
  localparam logic [2:0] AluCtrlOr  = 3'b011;
  localparam logic [2:0] AluCtrlXor = 3'b100;
  localparam logic [2:0] AluCtrlSlt = 3'b101;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_alu_dec.sv
// ALU decoder: maps the controller's alu_op class plus instruction funct fields
// to a 3-bit ALU control code. Purely combinational; sits beside main_fsm.
//   alu_op      in  2  operation class from main_fsm
//   funct3      in  3  instruction funct3
//   funct7_5    in  1  instruction funct7[5]
//   op_5        in  1  opcode bit 5 (distinguishes R-type from I-type)
//   alu_control out 3  ALU operation select
module alu_dec
  import main_fsm_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluCtrlAdd;
    case (alu_op)
      AluOpAdd: alu_control = AluCtrlAdd;
      AluOpSub: alu_control = AluCtrlSub;
      AluOpFunct: begin
        case (funct3)
          // Only R-type SUB has funct7[5] set; ADDI reuses those bits as immediate.
          3'b000:  alu_control = (op_5 && funct7_5) ? AluCtrlSub : AluCtrlAdd;
          3'b010:  alu_control = AluCtrlSlt;
          3'b100:  alu_control = AluCtrlXor;
          3'b110:  alu_control = AluCtrlOr;
          3'b111:  alu_control = AluCtrlAnd;
          default: alu_control = AluCtrlAdd;
        endcase
      end
      default: alu_control = AluCtrlAdd;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller. Moore-style decode of the state register,
// with mem_ready gating fetch strobes and the store completion pulse.
//   clk, rst_n              clock, asynchronous active-low reset
//   op                      opcode field of the instruction register
//   mem_ready               memory access completes this cycle
//   pc_update, branch       PC write requests
//   reg_write, mem_write    register-file / data-memory writes
//   ir_write                instruction-register load
//   adr_src, result_src     address / result mux selects
//   alu_src_a, alu_src_b    ALU operand selects
//   alu_op                  ALU operation class (decoded by alu_dec)
//   halted                  illegal-opcode trap active
//   instr_done              pulse on the last cycle of each instruction
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       pc_update,
  output logic       branch,
  output logic       reg_write,
  output logic       mem_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       instr_done
);

  state_t state_q;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:    if (mem_ready) state_q <= StDecode;
        StDecode: begin
          case (op)
            OpLoad, OpStore: state_q <= StMemAdr;
            OpRtype:         state_q <= StExecuteR;
            OpItype:         state_q <= StExecuteI;
            OpBeq:           state_q <= StBeq;
            OpJal:           state_q <= StJal;
            OpJalr:          state_q <= StJalr;
            OpLui:           state_q <= StLui;
            OpAuipc:         state_q <= StAuipc;
            default:         state_q <= StTrap;
          endcase
        end
        StMemAdr:   state_q <= op[5] ? StMemWrite : StMemRead;
        StMemRead:  if (mem_ready) state_q <= StMemWb;
        StMemWrite: if (mem_ready) state_q <= StFetch;
        StExecuteR, StExecuteI, StLui, StAuipc, StJal: state_q <= StAluWb;
        // JALR computes the target, then reuses JAL to write PC and link.
        StJalr:     state_q <= StJal;
        StMemWb, StAluWb, StBeq: state_q <= StFetch;
        StTrap:     state_q <= StTrap;
        default:    state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      StFetch: begin
        ctrl.adr_src    = AdrPc;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_update  = mem_ready;
        ctrl.alu_src_b  = SrcBFour;
        ctrl.result_src = ResAluResult;
      end
      StDecode: begin
        ctrl.alu_src_a = SrcAOldPc;
        ctrl.alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        ctrl.alu_src_a = SrcARs1;
        ctrl.alu_src_b = SrcBImm;
      end
      StMemRead:  ctrl.adr_src = AdrResult;
      StMemWb: begin
        ctrl.result_src = ResData;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWrite: begin
        ctrl.adr_src    = AdrResult;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      StExecuteR: begin
        ctrl.alu_src_a = SrcARs1;
        ctrl.alu_op    = AluOpFunct;
      end
      StExecuteI: begin
        ctrl.alu_src_a = SrcARs1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluOpFunct;
      end
      StAluWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StBeq: begin
        ctrl.alu_src_a  = SrcARs1;
        ctrl.alu_op     = AluOpSub;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StJal: begin
        ctrl.alu_src_a = SrcAOldPc;
        ctrl.alu_src_b = SrcBFour;
        ctrl.pc_update = 1'b1;
      end
      StJalr: begin
        ctrl.alu_src_a = SrcARs1;
        ctrl.alu_src_b = SrcBImm;
      end
      StLui: begin
        ctrl.alu_src_a = SrcAZero;
        ctrl.alu_src_b = SrcBImm;
      end
      StAuipc: begin
        ctrl.alu_src_a = SrcAOldPc;
        ctrl.alu_src_b = SrcBImm;
      end
      StTrap:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
    // Reset parks the state in FETCH, whose selects are non-zero; force every
    // output low while reset is held so nothing downstream sees a fetch.
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  assign pc_update  = ctrl.pc_update;
  assign branch     = ctrl.branch;
  assign reg_write  = ctrl.reg_write;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign halted     = ctrl.halted;
  assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm with alu_dec instantiated beside it.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       pc_update, branch, reg_write, mem_write, ir_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       halted, instr_done;

  logic [1:0] dec_alu_op;
  logic [2:0] dec_funct3;
  logic       dec_funct7_5, dec_op_5;
  logic [2:0] dec_alu_control;

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;

  always #5 clk = ~clk;

  main_fsm u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .pc_update  (pc_update),
    .branch     (branch),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .halted     (halted),
    .instr_done (instr_done)
  );

  alu_dec u_alu_dec (
    .alu_op      (dec_alu_op),
    .funct3      (dec_funct3),
    .funct7_5    (dec_funct7_5),
    .op_5        (dec_op_5),
    .alu_control (dec_alu_control)
  );

  // {pc_update, branch, reg_write, mem_write, ir_write, adr_src,
  //  result_src, alu_src_a, alu_src_b, alu_op, halted, instr_done}
  logic [15:0] obs;
  assign obs = {pc_update, branch, reg_write, mem_write, ir_write, adr_src,
                result_src, alu_src_a, alu_src_b, alu_op, halted, instr_done};

  function automatic logic [15:0] mk(input logic pc, input logic br, input logic rw,
                                     input logic mw, input logic ir, input logic adr,
                                     input logic [1:0] res, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] aop,
                                     input logic h, input logic d);
    return {pc, br, rw, mw, ir, adr, res, a, b, aop, h, d};
  endfunction

  // Hand-written expected output words per state.
  logic [15:0] e_zero, e_fetch, e_fstall, e_decode, e_memadr, e_memread, e_memwb;
  logic [15:0] e_mw_wait, e_mw_done, e_exer, e_exei, e_aluwb, e_beq, e_jal, e_jalr;
  logic [15:0] e_lui, e_auipc, e_trap;

  initial begin
    e_zero    = '0;
    e_fetch   = mk(1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    e_fstall  = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    e_decode  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
    e_memadr  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    e_memread = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    e_memwb   = mk(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1);
    e_mw_wait = mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    e_mw_done = mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
    e_exer    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    e_exei    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
    e_aluwb   = mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
    e_beq     = mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1);
    e_jal     = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
    e_jalr    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    e_lui     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, 0, 0);
    e_auipc   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
    e_trap    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic mr, input logic [15:0] exp);
    mem_ready = mr;
    #1;
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    op           = 7'b0000011;
    mem_ready    = 1'b1;
    dec_alu_op   = 2'b00;
    dec_funct3   = 3'b000;
    dec_funct7_5 = 1'b0;
    dec_op_5     = 1'b0;
    #2;
    check("reset_outputs", obs, e_zero);
    @(posedge clk);
    #1;
    check("reset_outputs_after_edge", obs, e_zero);
    rst_n = 1'b1;

    // LW: FETCH DECODE MEMADR MEMREAD MEMWB
    op = 7'b0000011;
    cyc("lw_fetch", 1, e_fetch);
    cyc("lw_decode", 1, e_decode);
    cyc("lw_memadr", 1, e_memadr);
    cyc("lw_memread", 1, e_memread);
    cyc("lw_memwb", 1, e_memwb);

    // SW with three wait cycles in MEMWRITE
    op = 7'b0100011;
    cyc("sw_fetch", 1, e_fetch);
    cyc("sw_decode", 1, e_decode);
    cyc("sw_memadr", 1, e_memadr);
    for (int i = 0; i < 3; i++) cyc("sw_memwrite_wait", 0, e_mw_wait);
    cyc("sw_memwrite_done", 1, e_mw_done);

    // JALR -> JAL -> ALUWB
    op = 7'b1100111;
    cyc("jalr_fetch", 1, e_fetch);
    cyc("jalr_decode", 1, e_decode);
    cyc("jalr_jalr", 1, e_jalr);
    cyc("jalr_jal", 1, e_jal);
    cyc("jalr_aluwb", 1, e_aluwb);

    // Fetch stalled two cycles, then R-type
    op = 7'b0110011;
    cyc("fetch_stall0", 0, e_fstall);
    cyc("fetch_stall1", 0, e_fstall);
    cyc("r_fetch", 1, e_fetch);
    cyc("r_decode", 1, e_decode);
    cyc("r_execute", 1, e_exer);
    cyc("r_aluwb", 1, e_aluwb);

    // BEQ: 3 cycles
    op = 7'b1100011;
    cyc("beq_fetch", 1, e_fetch);
    cyc("beq_decode", 1, e_decode);
    cyc("beq_beq", 1, e_beq);

    // I-type
    op = 7'b0010011;
    cyc("i_fetch", 1, e_fetch);
    cyc("i_decode", 1, e_decode);
    cyc("i_execute", 1, e_exei);
    cyc("i_aluwb", 1, e_aluwb);

    // LUI
    op = 7'b0110111;
    cyc("lui_fetch", 1, e_fetch);
    cyc("lui_decode", 1, e_decode);
    cyc("lui_lui", 1, e_lui);
    cyc("lui_aluwb", 1, e_aluwb);

    // AUIPC
    op = 7'b0010111;
    cyc("auipc_fetch", 1, e_fetch);
    cyc("auipc_decode", 1, e_decode);
    cyc("auipc_auipc", 1, e_auipc);
    cyc("auipc_aluwb", 1, e_aluwb);

    // JAL
    op = 7'b1101111;
    cyc("jal_fetch", 1, e_fetch);
    cyc("jal_decode", 1, e_decode);
    cyc("jal_jal", 1, e_jal);
    cyc("jal_aluwb", 1, e_aluwb);

    // LW with MEMREAD stalled one cycle
    op = 7'b0000011;
    cyc("lws_fetch", 1, e_fetch);
    cyc("lws_decode", 1, e_decode);
    cyc("lws_memadr", 1, e_memadr);
    cyc("lws_memread_wait", 0, e_memread);
    cyc("lws_memread", 1, e_memread);
    cyc("lws_memwb", 1, e_memwb);

    // Illegal opcode -> TRAP for 20 cycles, mem_ready toggling
    op = 7'b1111111;
    cyc("trap_fetch", 1, e_fetch);
    cyc("trap_decode", 1, e_decode);
    for (int i = 0; i < 20; i++) cyc("trap_hold", logic'(i[0]), e_trap);
    rst_n = 1'b0;
    #1;
    check("trap_reset_outputs", obs, e_zero);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("trap_release_fetch", obs, e_fetch);
    @(posedge clk);
    #1;

    // Reset mid-instruction in MEMADR, asserted between edges
    op = 7'b0000011;
    cyc("mid_decode", 1, e_decode);
    mem_ready = 1'b1;
    #1;
    check("mid_memadr", obs, e_memadr);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", obs, e_zero);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("mid_release_fetch", 1, e_fetch);
    cyc("mid_release_decode", 1, e_decode);

    // alu_dec vectors: {alu_op, funct3, funct7_5, op_5} -> alu_control
    begin
      logic [2:0] dec_exp [8];
      logic [6:0] dec_in  [8];
      dec_in[0] = {2'b00, 3'b111, 1'b1, 1'b1}; dec_exp[0] = 3'b000;
      dec_in[1] = {2'b01, 3'b000, 1'b0, 1'b0}; dec_exp[1] = 3'b001;
      dec_in[2] = {2'b10, 3'b000, 1'b1, 1'b1}; dec_exp[2] = 3'b001;
      dec_in[3] = {2'b10, 3'b000, 1'b1, 1'b0}; dec_exp[3] = 3'b000;
      dec_in[4] = {2'b10, 3'b010, 1'b0, 1'b1}; dec_exp[4] = 3'b101;
      dec_in[5] = {2'b10, 3'b110, 1'b0, 1'b1}; dec_exp[5] = 3'b011;
      dec_in[6] = {2'b10, 3'b111, 1'b0, 1'b0}; dec_exp[6] = 3'b010;
      dec_in[7] = {2'b10, 3'b100, 1'b0, 1'b1}; dec_exp[7] = 3'b100;
      for (int i = 0; i < 8; i++) begin
        {dec_alu_op, dec_funct3, dec_funct7_5, dec_op_5} = dec_in[i];
        #1;
        check($sformatf("alu_dec_%0d", i), {13'd0, dec_alu_control}, {13'd0, dec_exp[i]});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
